// File: rtl/expr_mixed_pipe.sv
// expr_mixed_pipe: per-channel mixed-signedness expression pipeline feeding an output FIFO with XOR checksum
module expr_mixed_pipe #(
  parameter int W     = 6,
  parameter int NCH   = 4,
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NCH*W-1:0]               in_a,
  input  logic [NCH*W-1:0]               in_b,
  input  logic [NCH*3-1:0]               in_op,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NCH*(W+2)-1:0]           out_y,
  output logic [$clog2(DEPTH+1)-1:0]     out_cnt,
  output logic [NCH*(W+2)-1:0]           chk
);
  localparam int R  = W + 2;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  function automatic logic [R-1:0] eval(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    logic [R-1:0] ua;
    logic signed [R-1:0] sb;
    logic signed [R-1:0] asr;
    logic gt_s;
    ua   = R'(a);
    sb   = {{(R-W){b[W-1]}}, b};
    asr  = sb >>> a[2:0];
    gt_s = $signed(ua) > sb;
    return op == 3'd0 ? ua + sb :
           op == 3'd1 ? ua - sb :
           op == 3'd2 ? R'(a > b) :
           op == 3'd3 ? R'(gt_s) :
           op == 3'd4 ? R'((^a) ^ (^b)) :
           op == 3'd5 ? ua >> b[2:0] :
           op == 3'd6 ? asr :
           (b[W-1] ? ua : sb);
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic [NCH*W-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [NCH*3-1:0]     s1_op_q, s1_op_d;
  logic [NCH*R-1:0]     mem_q [DEPTH];
  logic [NCH*R-1:0]     mem_d [DEPTH];
  logic [PW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NCH*R-1:0]     hold_q, hold_d, chk_q, chk_d, res;
  logic [CW:0]          occ;
  logic                 accept, push, pop;

  // evaluate every channel of the stage-1 transaction
  always_comb begin
    res = '0;
    for (int c = 0; c < NCH; c++) res[c*R +: R] = eval(s1_a_q[c*W +: W], s1_b_q[c*W +: W], s1_op_q[c*3 +: 3]);
  end

  // handshake from registers only; stage-1 occupancy is reserved as FIFO credit
  always_comb begin
    occ       = {1'b0, cnt_q} + {{CW{1'b0}}, s1_valid_q};
    in_ready  = occ < (CW+1)'(DEPTH);
    out_valid = cnt_q != '0;
    accept    = in_valid & in_ready;
    push      = s1_valid_q;
    pop       = out_valid & out_ready;
    out_y     = out_valid ? mem_q[rd_q] : hold_q;
    out_cnt   = cnt_q;
    chk       = chk_q;
  end

  // next-state for stage 1, FIFO storage and pointers, last-popped hold and checksum
  always_comb begin
    s1_valid_d = accept;
    s1_a_d     = accept ? in_a : s1_a_q;
    s1_b_d     = accept ? in_b : s1_b_q;
    s1_op_d    = accept ? in_op : s1_op_q;
    mem_d      = mem_q;
    if (push) mem_d[wr_q] = res;
    wr_d       = push ? wr_q + PW'(1) : wr_q;
    rd_d       = pop ? rd_q + PW'(1) : rd_q;
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    hold_d     = pop ? out_y : hold_q;
    chk_d      = pop ? chk_q ^ out_y : chk_q;
  end

  // state registers with synchronous reset that flushes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      chk_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      chk_q      <= chk_d;
    end
  end
endmodule

// File: tb/tb_expr_mixed_pipe.sv
// tb_expr_mixed_pipe: directed self-checking bench for expr_mixed_pipe
module tb_expr_mixed_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [23:0] in_a, in_b;
  logic [11:0] in_op;
  logic [31:0] out_y, chk;
  logic [2:0]  out_cnt;
  int          total = 0;
  int          bad = 0;
  int          acc, k;
  logic        go;

  always #5 clk = ~clk;

  expr_mixed_pipe #(.W(6), .NCH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_cnt(out_cnt), .chk(chk)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    check("rst_out_y", out_y, 32'd0);
    check("rst_chk", chk, 32'd0);
    rst = 1'b0;

    in_a = {4{6'd5}}; in_b = {4{6'h3D}}; in_op = {3'd3, 3'd2, 3'd1, 3'd0}; in_valid = 1'b1;
    @(negedge clk);
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    in_a = {6'd1, 6'd40, 6'd5, 6'd5}; in_b = {6'h3D, 6'd3, 6'h3D, 6'h3D}; in_op = {3'd6, 3'd5, 3'd7, 3'd4};
    @(negedge clk);
    check("lat_e2_valid", 32'(out_valid), 32'd1);
    check("ops0123", out_y, 32'h01000802);
    check("eval_cnt1", 32'(out_cnt), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("ops4756", out_y, 32'hFE050501);
    check("eval_cnt2", 32'(out_cnt), 32'd1);
    @(negedge clk);
    check("eval_empty", 32'(out_valid), 32'd0);
    check("eval_chk", chk, 32'hFF050D03);

    rst = 1'b1; @(negedge clk); rst = 1'b0;
    check("rst2_chk", chk, 32'd0);
    in_a = {4{6'd5}}; in_b = {4{6'h3D}}; in_op = {4{3'd0}}; in_valid = 1'b1;
    @(negedge clk);
    check("str_e1_valid", 32'(out_valid), 32'd0);
    in_op = {4{3'd1}};
    @(negedge clk);
    check("str_y0", out_y, 32'h02020202);
    check("str_cnt0", 32'(out_cnt), 32'd1);
    check("str_ready", 32'(in_ready), 32'd1);
    in_op = {4{3'd7}};
    @(negedge clk);
    check("str_y1", out_y, 32'h08080808);
    check("str_cnt1", 32'(out_cnt), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    check("str_y2", out_y, 32'h05050505);
    check("str_cnt2", 32'(out_cnt), 32'd1);
    @(negedge clk);
    check("str_empty", 32'(out_cnt), 32'd0);
    check("str_chk", chk, 32'h0F0F0F0F);

    rst = 1'b1; @(negedge clk); rst = 1'b0;
    out_ready = 1'b0; k = 1; acc = 0;
    in_a = {4{6'(k)}}; in_b = '0; in_op = '0; in_valid = 1'b1;
    repeat (8) begin
      go = in_ready;
      @(negedge clk);
      if (go) begin
        acc++; k++;
        in_a = {4{6'(k)}};
      end
    end
    check("bp_accepts", 32'(acc), 32'd4);
    check("bp_ready", 32'(in_ready), 32'd0);
    check("bp_cnt", 32'(out_cnt), 32'd4);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_pop_valid", 32'(out_valid), 32'd1);
      check("bp_pop_y", out_y, {4{8'(i)}});
      @(negedge clk);
    end
    check("bp_drained", 32'(out_cnt), 32'd0);
    check("bp_chk", chk, 32'h04040404);

    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_a = {4{6'(i + 8)}}; in_valid = 1'b1;
      @(negedge clk);
    end
    check("mid_cnt3", 32'(out_cnt), 32'd3);
    check("mid_full", 32'(in_ready), 32'd0);
    rst = 1'b1; @(negedge clk); rst = 1'b0; in_valid = 1'b0;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_cnt", 32'(out_cnt), 32'd0);
    check("mid_chk", chk, 32'd0);
    check("mid_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("mid_no_survivor", 32'(out_cnt), 32'd0);
    in_a = {4{6'd5}}; in_b = {4{6'h3D}}; in_op = '0; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check("post_e1_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    check("post_e2_valid", 32'(out_valid), 32'd1);
    check("post_y", out_y, 32'h02020202);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/expr_mixed_pipe.md
Name: expr_mixed_pipe

Overview:
- Multi-channel, pipelined mixed-signedness expression evaluator for the vloghammer regression family.
- Each channel combines an unsigned operand and a signed operand under a selectable opcode. Results carry exact Verilog width/sign-extension semantics.
- Results are buffered in an output FIFO behind a valid/ready handshake.
- A per-channel XOR checksum of all delivered results gives a compact regression signature.

Parameters:
- W, 6, operand width per channel (2..16).
- NCH, 4, number of independent channels sharing one handshake.
- DEPTH, 4, output FIFO depth in transactions (power of 2, >=2).
- R (local), W+2, result width per channel.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  input transaction present.
- in_ready  out  1  block can accept the transaction this cycle.
- in_a  in  NCH*W  unsigned operands; channel c at bits [c*W +: W].
- in_b  in  NCH*W  signed (two's complement) operands; same packing.
- in_op  in  NCH*3  per-channel opcode; channel c at [c*3 +: 3].
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_y  out  NCH*R  head results; channel c at [c*R +: R].
- out_cnt  out  clog2(DEPTH+1)  FIFO occupancy.
- chk  out  NCH*R  per-channel XOR of every popped result.

Behaviour:
- Reset: in_ready=1, out_valid=0, out_y=0, out_cnt=0, chk=0, stage-1 valid=0, FIFO pointers=0.
- Reset wins over any simultaneous push or pop. Reset asserted mid-operation flushes stage 1 and the FIFO. No transaction survives reset.
- Accept occurs when in_valid & in_ready at a rising edge. Operands and opcodes are registered into stage 1 (s1_valid=1).
- Stage 2: the combinational evaluation of stage-1 registers is written into the FIFO at the next edge.
- out_valid rises after the second edge following accept (latency 2) when the FIFO was empty. No bypass path.
- in_ready = (out_cnt + s1_valid) < DEPTH. It is a function of registers only, with no combinational path from out_ready. In-flight credit guarantees a stage-1 result always has a FIFO slot, so there is no stall inside the pipe.
- Throughput: 1 transaction/cycle while the consumer keeps out_ready=1.
- Pop occurs when out_valid & out_ready. On the same edge, chk[c] ^= out_y[c] for every channel.
- Push and pop on the same edge: out_cnt unchanged; both pointers advance modulo DEPTH.
- FIFO full: in_ready=0 whenever out_cnt + s1_valid = DEPTH; in_valid is ignored.
- Empty: out_valid=0 and out_y holds its last value; the bench must not check out_y while out_valid=0.
- Evaluation per channel: A = zero-extend(a) to R, B = sign-extend(b) to R, all arithmetic modulo 2^R.
  - op0: A + B.
  - op1: A - B.
  - op2: unsigned compare, a > b with b taken as raw unsigned W bits; result zero-extended 1 bit.
  - op3: signed compare, A > B as signed R-bit; result zero-extended 1 bit.
  - op4: parity (^a) ^ (^b), zero-extended.
  - op5: logical shift, A >> b[2:0] (b low bits as unsigned amount).
  - op6: arithmetic shift, B >>> a[2:0], keeping the sign in R bits.
  - op7: select, (b negative) ? A : B.
- Channels are fully independent; any opcode mix per transaction is legal.

Test Plan:
- W=6, a=5, b=-3 (6'b111101), op0 -> y=2; op1 -> y=8; op2 -> 0 (5>61 false); op3 -> 1; op4 -> 1; op7 -> 5. One opcode per channel over two transactions, each checked against a golden model.
- a=40, b=3, op5 -> 5; a=1, b=-3, op6 -> R-bit -2 (8'hFE). Covers shift sign semantics.
- Backpressure: out_ready=0, stream with in_valid=1 -> exactly DEPTH accepts, then in_ready=0 with out_cnt=DEPTH. Release out_ready -> results pop in order with no loss or duplicates.
- Steady stream, out_ready=1 -> one accept and one pop per cycle; out_cnt constant at 1; first out_valid exactly 2 edges after first accept.
- Checksum: pop results 2, 8, 5 on channel 0 -> chk[0]=2^8^5=15.
- Reset mid-stream with FIFO at 3 and s1_valid=1 -> next cycle out_valid=0, out_cnt=0, chk=0, in_ready=1. Post-reset transaction emerges with latency 2.
